// File: rtl/master_bus_bridge.sv
// Initiator end of the bit-serial system bus: shifts {addr, wdata} out on wr_bus,
// collects read data from rd_bus, tolerates slave split and aborts on stall timeout.
module master_bus_bridge #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_in,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0]   uart_register_in,
  output logic                             ready_out,
  output logic                             wr_bus,
  output logic                             mode,
  output logic                             master_valid,
  input  logic                             slave_ready,
  input  logic                             rd_bus,
  input  logic                             slave_valid,
  output logic                             master_ready,
  input  logic                             split,
  output logic [DATA_WIDTH-1:0]            uart_register_out,
  output logic                             valid_out,
  output logic                             error
);

  localparam int unsigned REQ_W   = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned MAX_W   = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W   = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int unsigned STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]   ADDR_LAST  = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]   DATA_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RD_WAIT, SPLIT, RD_DATA, DONE} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STALL_W-1:0]     stall_q, stall_d;
  logic [REQ_W-1:0]       sh_q, sh_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]  out_q, out_d;
  logic                   mode_q, mode_d;
  logic                   ready_out_q, ready_out_d;
  logic                   wr_bus_q, wr_bus_d;
  logic                   master_valid_q, master_valid_d;
  logic                   master_ready_q, master_ready_d;
  logic                   valid_out_q, valid_out_d;
  logic                   error_q, error_d;
  logic                   wr_xfer_c, rd_xfer_c, stall_en_c;
  logic [DATA_WIDTH-1:0]  rd_shift_c;

  assign wr_xfer_c  = master_valid_q && slave_ready;
  assign rd_xfer_c  = master_ready_q && slave_valid && !((state_q == RD_WAIT) && split);
  assign rd_shift_c = DATA_WIDTH'({rdata_q, rd_bus});
  // A split request in RD_WAIT is a legal wait, so it never counts as a stall.
  assign stall_en_c = (state_q == ADDR) || (state_q == DATA) || (state_q == RD_DATA) ||
                      ((state_q == RD_WAIT) && !split);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    sh_d    = sh_q;
    rdata_d = rdata_q;
    out_d   = out_q;
    mode_d  = mode_q;
    error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          sh_d    = uart_register_in[REQ_W-1:0];
          mode_d  = uart_register_in[REQ_W];
          cnt_d   = '0;
          stall_d = '0;
          rdata_d = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (wr_xfer_c) begin
          sh_d = {sh_q[REQ_W-2:0], 1'b0};
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = mode_q ? DATA : RD_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (wr_xfer_c) begin
          sh_d = {sh_q[REQ_W-2:0], 1'b0};
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RD_WAIT: begin
        if (split) begin
          state_d = SPLIT;
        end else if (rd_xfer_c) begin
          rdata_d = rd_shift_c;
          if (DATA_WIDTH == 1) begin
            out_d   = rd_shift_c;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = RD_DATA;
          end
        end
      end
      SPLIT: begin
        if (!split) state_d = RD_WAIT;
      end
      RD_DATA: begin
        if (rd_xfer_c) begin
          rdata_d = rd_shift_c;
          if (cnt_q == DATA_LAST) begin
            out_d   = rd_shift_c;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Stall watchdog overrides any other transition on expiry.
    if (stall_en_c) begin
      if (wr_xfer_c || rd_xfer_c) begin
        stall_d = '0;
      end else if (TIMEOUT != 0) begin
        if (stall_q == STALL_LAST) begin
          stall_d = '0;
          cnt_d   = '0;
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
    end

    ready_out_d    = (state_d == IDLE);
    master_valid_d = (state_d == ADDR) || (state_d == DATA);
    master_ready_d = (state_d == RD_WAIT) || (state_d == RD_DATA);
    wr_bus_d       = master_valid_d & sh_d[REQ_W-1];
    valid_out_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_q        <= '0;
      sh_q           <= '0;
      rdata_q        <= '0;
      out_q          <= '0;
      mode_q         <= 1'b0;
      ready_out_q    <= 1'b1;
      wr_bus_q       <= 1'b0;
      master_valid_q <= 1'b0;
      master_ready_q <= 1'b0;
      valid_out_q    <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_q        <= stall_d;
      sh_q           <= sh_d;
      rdata_q        <= rdata_d;
      out_q          <= out_d;
      mode_q         <= mode_d;
      ready_out_q    <= ready_out_d;
      wr_bus_q       <= wr_bus_d;
      master_valid_q <= master_valid_d;
      master_ready_q <= master_ready_d;
      valid_out_q    <= valid_out_d;
      error_q        <= error_d;
    end
  end

  assign ready_out         = ready_out_q;
  assign wr_bus            = wr_bus_q;
  assign mode              = mode_q;
  assign master_valid      = master_valid_q;
  assign master_ready      = master_ready_q;
  assign uart_register_out = out_q;
  assign valid_out         = valid_out_q;
  assign error             = error_q;

endmodule

// File: tb/tb_master_bus_bridge.sv
// Scoreboard bench for master_bus_bridge: stimulus pushes expected bits/events,
// a negedge monitor pops and compares whenever the bridge transfers or pulses.
module tb_master_bus_bridge;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [AW+DW:0] uart_register_in;
  logic          ready_out, wr_bus, mode, master_valid, master_ready;
  logic          slave_ready, rd_bus, slave_valid, split;
  logic [DW-1:0] uart_register_out;
  logic          valid_out, error;

  master_bus_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .uart_register_in(uart_register_in),
    .ready_out(ready_out), .wr_bus(wr_bus), .mode(mode), .master_valid(master_valid),
    .slave_ready(slave_ready), .rd_bus(rd_bus), .slave_valid(slave_valid),
    .master_ready(master_ready), .split(split), .uart_register_out(uart_register_out),
    .valid_out(valid_out), .error(error)
  );

  always #5 clk = ~clk;

  // kind: 0 = write done, 1 = read done (data checked), 2 = timeout error
  typedef struct {
    int            kind;
    logic [DW-1:0] data;
  } evt_t;

  logic    bit_q[$];
  evt_t    evt_q[$];
  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  int      last_wr_cyc = 0;
  int      mv_cnt = 0;
  int      wr_xfers = 0;
  logic    cur_mode = 1'b0;
  logic [DW-1:0] exp_out = '0;
  logic    sr_val = 1'b1;
  logic    tog_en = 1'b0;
  int      tog_k = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Slave write-side handshake: constant, or alternating 1/0 from the first master_valid cycle.
  always @(posedge clk) begin
    #1;
    if (master_valid) begin
      slave_ready = tog_en ? ~tog_k[0] : sr_val;
      tog_k++;
    end else begin
      slave_ready = tog_en ? 1'b1 : sr_val;
      tog_k = 0;
    end
  end

  // Monitor: compare serial bits on every write transfer and every output pulse.
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (master_valid) mv_cnt++;
      if (master_valid && slave_ready) begin
        if (bit_q.size() == 0) begin
          chk("unexpected_wr_bit", 32'(wr_bus), 32'hFFFF_FFFF);
        end else begin
          chk("wr_bus_bit", 32'(wr_bus), 32'(bit_q.pop_front()));
        end
        chk("mode_during_xfer", 32'(mode), 32'(cur_mode));
        last_wr_cyc = cyc;
        wr_xfers++;
      end
      if (valid_out || error) begin
        int   act_kind;
        evt_t e;
        act_kind = (valid_out && error) ? 3 : (error ? 2 : (mode ? 0 : 1));
        if (evt_q.size() == 0) begin
          chk("unexpected_event", 32'(act_kind), 32'hFFFF_FFFF);
        end else begin
          e = evt_q.pop_front();
          chk("event_kind", 32'(act_kind), 32'(e.kind));
          if (e.kind == 1) begin
            chk("read_data", 32'(uart_register_out), 32'(e.data));
            exp_out = e.data;
          end else if (e.kind == 0) begin
            chk("write_keeps_out", 32'(uart_register_out), 32'(exp_out));
            chk("valid_out_latency", 32'(cyc - last_wr_cyc), 32'd1);
          end
        end
      end
    end
  end

  task automatic send_req(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] rd_exp, input logic exp_err);
    int   n = 0;
    evt_t e;
    while (!ready_out && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before_req", 32'(ready_out), 32'd1);
    cur_mode = m;
    for (int i = AW - 1; i >= 0; i--) bit_q.push_back(a[i]);
    if (m) for (int i = DW - 1; i >= 0; i--) bit_q.push_back(d[i]);
    e.kind = exp_err ? 2 : (m ? 0 : 1);
    e.data = rd_exp;
    evt_q.push_back(e);
    mv_cnt   = 0;
    wr_xfers = 0;
    valid_in = 1'b1;
    uart_register_in = {m, a, d};
    @(posedge clk); #1;
    valid_in = 1'b0;
    uart_register_in = '1;
  endtask

  task automatic wait_events(input string name);
    int n = 0;
    while (evt_q.size() != 0 && n < 400) begin
      @(negedge clk); n++;
    end
    chk(name, 32'(evt_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_mr();
    int n = 0;
    while (!master_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("master_ready_rise", 32'(master_ready), 32'd1);
  endtask

  task automatic send_rd_bits(input logic [DW-1:0] d, input int gap);
    wait_mr();
    for (int i = DW - 1; i >= 0; i--) begin
      slave_valid = 1'b1;
      rd_bus = d[i];
      @(posedge clk); #1;
      slave_valid = 1'b0;
      rd_bus = 1'b0;
      chk("mode_read", 32'(mode), 32'd0);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready_out"}, 32'(ready_out), 32'd1);
    chk({tag, "_outs_low"}, 32'({wr_bus, mode, master_valid, master_ready, valid_out, error}), 32'd0);
    chk({tag, "_uart_out"}, 32'(uart_register_out), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    uart_register_in = '0;
    rd_bus = 1'b0;
    slave_valid = 1'b0;
    split = 1'b0;
    slave_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write, slave always ready
    sr_val = 1'b1;
    send_req(1'b1, 16'hA55A, 8'h3C, 8'h00, 1'b0);
    wait_events("write_done");
    chk("write_mv_cycles", 32'(mv_cnt), 32'd24);

    // Write, slave_ready alternating
    tog_en = 1'b1;
    send_req(1'b1, 16'hA55A, 8'h3C, 8'h00, 1'b0);
    wait_events("write_toggle_done");
    chk("toggle_mv_cycles", 32'(mv_cnt), 32'd47);
    tog_en = 1'b0;

    // Read with gaps between data bits
    send_req(1'b0, 16'h0010, 8'hEE, 8'hC3, 1'b0);
    send_rd_bits(8'hC3, 2);
    wait_events("read_done");

    // Read with a 50-cycle split; first split cycle also carries slave_valid
    send_req(1'b0, 16'h00F0, 8'h00, 8'h5A, 1'b0);
    wait_mr();
    split = 1'b1;
    slave_valid = 1'b1;
    rd_bus = 1'b1;
    @(posedge clk); #1;
    slave_valid = 1'b0;
    rd_bus = 1'b0;
    for (int i = 0; i < 49; i++) begin
      chk("split_master_ready", 32'(master_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("split_no_error_pending", 32'(evt_q.size()), 32'd1);
    split = 1'b0;
    send_rd_bits(8'h5A, 1);
    wait_events("split_read_done");

    // Timeout: slave never ready
    sr_val = 1'b0;
    send_req(1'b1, 16'h1357, 8'h9B, 8'h00, 1'b1);
    wait_events("timeout_error");
    chk("timeout_mv_cycles", 32'(mv_cnt), 32'(TO));
    chk("timeout_ready_out", 32'(ready_out), 32'd1);
    chk("timeout_uart_out", 32'(uart_register_out), 32'(exp_out));
    bit_q.delete();
    sr_val = 1'b1;

    // Reset after 20 bits of a write, then a clean write
    send_req(1'b1, 16'h1234, 8'hA5, 8'h00, 1'b0);
    begin
      int n = 0;
      while (wr_xfers < 20 && n < 200) begin
        @(posedge clk); n++;
      end
      chk("bits_before_reset", 32'(wr_xfers), 32'd20);
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    bit_q.delete();
    evt_q.delete();
    exp_out = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send_req(1'b1, 16'hBEEF, 8'h77, 8'h00, 1'b0);
    wait_events("post_reset_write");
    chk("post_reset_mv_cycles", 32'(mv_cnt), 32'd24);

    repeat (3) @(posedge clk);
    chk("bits_left", 32'(bit_q.size()), 32'd0);
    chk("events_left", 32'(evt_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/master_bus_bridge.md
Name: master_bus_bridge

Overview:
- Initiator end of the bit-serial system bus.
- Accepts one parallel request word {mode, addr, data} from the UART-side register, latches it, and shifts address then write data MSB-first onto wr_bus under the master_valid/slave_ready handshake.
- For reads, it collects DATA_WIDTH bits from rd_bus under slave_valid/master_ready and presents them as a parallel word.
- It tolerates slave split, and aborts on a handshake timeout.

Parameters:
- ADDR_WIDTH, 16, address bits shifted per transaction.
- DATA_WIDTH, 8, data bits per write or read.
- TIMEOUT, 255, max consecutive stall cycles before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- valid_in  input  1  request present on uart_register_in
- uart_register_in  input  1+ADDR_WIDTH+DATA_WIDTH  {mode, addr, wdata}; mode 1 = write, 0 = read
- ready_out  output  1  bridge idle, request accepted when valid_in && ready_out
- wr_bus  output  1  serial address/write-data bit to slave
- mode  output  1  latched transaction mode, stable for the whole transaction
- master_valid  output  1  wr_bus bit valid
- slave_ready  input  1  slave accepting the wr_bus bit
- rd_bus  input  1  serial read-data bit from slave
- slave_valid  input  1  rd_bus bit valid
- master_ready  output  1  bridge accepting the rd_bus bit
- split  input  1  slave has split the read transaction
- uart_register_out  output  DATA_WIDTH  collected read data
- valid_out  output  1  one-cycle pulse: uart_register_out valid (read) or write complete
- error  output  1  one-cycle pulse: transaction aborted by timeout

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - ready_out=1. wr_bus, mode, master_valid, master_ready, valid_out, error = 0.
  - uart_register_out=0. Bit counter and stall counter = 0.
- A bit transfers only on a rising edge where master_valid && slave_ready (write side) or slave_valid && master_ready (read side). No other cycle advances the bit counter.
- States:
  - IDLE: ready_out=1. On valid_in, latch the request word and mode, clear counters, go to ADDR. ready_out is low in every other state.
  - ADDR: master_valid=1; wr_bus = addr[ADDR_WIDTH-1-cnt].
    - After the transfer at cnt=ADDR_WIDTH-1, clear cnt.
    - Then mode=1 goes to DATA; mode=0 goes to RD_WAIT.
    - The bit value is held unchanged while slave_ready=0.
  - DATA: master_valid=1; wr_bus = wdata[DATA_WIDTH-1-cnt]. After the transfer at cnt=DATA_WIDTH-1, go to DONE.
  - RD_WAIT: master_valid=0, master_ready=1.
    - split=1 goes to SPLIT.
    - A transfer shifts rd_bus into the data register MSB-first, increments cnt, and moves to RD_DATA.
    - If DATA_WIDTH=1, that transfer goes straight to DONE.
  - SPLIT: master_ready=0, master_valid=0. The stall counter is frozen here (split is a legal indefinite wait). split=0 returns to RD_WAIT.
  - RD_DATA: master_ready=1. Shift on each transfer. After the bit at cnt=DATA_WIDTH-1, copy the data register to uart_register_out and go to DONE. split in this state is ignored.
  - DONE: valid_out=1 for exactly one cycle, then IDLE. uart_register_out is unchanged by writes and holds until the next read completes.
- Timeout:
  - The stall counter increments on every cycle in ADDR/DATA/RD_WAIT/RD_DATA without a transfer, and resets on each transfer.
  - When it reaches TIMEOUT: pulse error for one cycle, drop master_valid/master_ready, go to IDLE.
  - valid_out is not asserted and uart_register_out is not updated.
- master_valid falls in the cycle after the last write bit transfers. No extra bit is ever driven.
- valid_in while busy is ignored (ready_out=0). The latched request is not disturbed by uart_register_in changes mid-transaction.
- rst asserted mid-transaction: immediate return to reset values. No valid_out or error pulse.
- Simultaneous slave_valid and split in RD_WAIT: split has priority, no bit sampled.

Test Plan:
- Write, slave_ready held high: request {1, 16'hA55A, 8'h3C} → master_valid high for exactly 24 cycles. wr_bus sequence = 1010010101011010 then 00111100. valid_out pulse 1 cycle later, error=0.
- Write with slave_ready toggling 1/0 each cycle → same 24-bit sequence. Each bit held during low cycles. Total 47 cycles from the first master_valid.
- Read: request {0, 16'h0010, x} → 16 address bits shifted, then master_ready=1. Slave sends 8'hC3 serially with gaps → uart_register_out=8'hC3 with valid_out pulse. mode=0 throughout.
- Read with split: split=1 for 50 cycles in RD_WAIT, TIMEOUT=10 → master_ready=0 during split, no error. After split=0, read of 8'h5A completes normally.
- Timeout: slave_ready stuck 0 → error pulse after exactly TIMEOUT stall cycles. Return to IDLE with ready_out=1; next valid_in accepted.
- Reset mid-DATA (after 20 bits) → all outputs at reset values asynchronously. No valid_out. A following write completes correctly from bit 0.
